// File: rtl/imem_loader.sv
// Serial instruction-memory loader: 16-bit LE word count, then LE 32-bit words written to imem.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-payload checksum byte.
module imem_loader #(
    parameter int unsigned AddressWidth = 10,
    parameter int unsigned DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_data_i,
    output logic                    byte_ready_o,
    output logic                    imem_ld_o,
    output logic [AddressWidth-1:0] imem_ld_addr_o,
    output logic [DataWidth-1:0]    imem_ld_data_o,
    output logic                    core_rst_o,
    output logic                    done_o,
    output logic                    err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StHdr0, StHdr1, StLoad, StCsum, StFlush, StDone, StErr
    } state_e;
    localparam state_e StAfterPayload = StCsum;
`else
    typedef enum logic [2:0] {
        StHdr0, StHdr1, StLoad, StFlush, StDone, StErr
    } state_e;
    localparam state_e StAfterPayload = StFlush;
`endif

    localparam logic [31:0] MaxWords = 32'd1 << AddressWidth;

    state_e                  state_q, state_d;
    logic [7:0]              n_lo_q, n_lo_d;
    logic [15:0]             last_idx_q, last_idx_d;
    logic [AddressWidth-1:0] word_idx_q, word_idx_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [23:0]             asm_q, asm_d;
    logic                    ld_q, ld_d;
    logic [AddressWidth-1:0] ld_addr_q, ld_addr_d;
    logic [DataWidth-1:0]    ld_data_q, ld_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] hdr_n;
    logic        oversize;
    logic        last_word;

    assign xfer      = byte_valid_i & byte_ready_o;
    assign hdr_n     = {byte_data_i, n_lo_q};
    assign oversize  = {16'd0, hdr_n} > MaxWords;
    assign last_word = {16'd0, last_idx_q} == 32'(word_idx_q);

    // Output decode is a pure function of state; the write strobe is gated so it
    // can only appear while the payload is in flight.
    always_comb begin
        byte_ready_o = 1'b0;
        core_rst_o   = 1'b1;
        done_o       = 1'b0;
        err_o        = 1'b0;
        imem_ld_o    = 1'b0;
        case (state_q)
            StHdr0, StHdr1: byte_ready_o = 1'b1;
            StLoad: begin
                byte_ready_o = 1'b1;
                imem_ld_o    = ld_q;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                byte_ready_o = 1'b1;
                imem_ld_o    = ld_q;
            end
`endif
            StFlush: imem_ld_o = ld_q;
            StDone: begin
                done_o     = 1'b1;
                core_rst_o = 1'b0;
            end
            StErr:   err_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_lo_d     = n_lo_q;
        last_idx_d = last_idx_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        ld_d       = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            StHdr0: begin
                if (xfer) begin
                    n_lo_d  = byte_data_i;
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (xfer) begin
                    last_idx_d = hdr_n - 16'd1;
                    if (hdr_n == 16'd0) begin
                        state_d = StAfterPayload;
                    end else if (oversize) begin
                        state_d = StErr;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_data_i;
`endif
                    unique case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = byte_data_i;
                        2'd1: asm_d[15:8]  = byte_data_i;
                        2'd2: asm_d[23:16] = byte_data_i;
                        2'd3: begin
                            // Final lane bypasses the assembly register so the word
                            // is registered straight into the strobe stage.
                            ld_d      = 1'b1;
                            ld_addr_d = word_idx_q;
                            ld_data_d = {byte_data_i, asm_q};
                            if (last_word) begin
                                state_d = StAfterPayload;
                            end else begin
                                word_idx_d = word_idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    state_d = (byte_data_i == csum_q) ? StFlush : StErr;
                end
            end
`endif
            StFlush: state_d = StDone;
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StHdr0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StHdr0;
            n_lo_q     <= 8'd0;
            last_idx_q <= 16'd0;
            word_idx_q <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            ld_q       <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            last_idx_q <= last_idx_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            ld_q       <= ld_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_ld_addr_o = ld_addr_q;
    assign imem_ld_data_o = ld_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed images against a stream-level model.
// Follows IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

    localparam int AW = 10;

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [31:0] word_q_t [$];

    logic          clk = 1'b0;
    logic          rst;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_ld;
    logic [AW-1:0] imem_ld_addr;
    logic [31:0]   imem_ld_data;
    logic          core_rst;
    logic          done;
    logic          err;

    imem_loader #(
        .AddressWidth(AW),
        .DataWidth   (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .byte_valid_i  (byte_valid),
        .byte_data_i   (byte_data),
        .byte_ready_o  (byte_ready),
        .imem_ld_o     (imem_ld),
        .imem_ld_addr_o(imem_ld_addr),
        .imem_ld_data_o(imem_ld_data),
        .core_rst_o    (core_rst),
        .done_o        (done),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Observations from the last drive_stream call.
    int          acc_cyc[$];
    int          st_addr[$];
    logic [31:0] st_data[$];
    int          st_cyc[$];
    int          done_cyc, err_cyc, crst_fall, consumed;

    // Reference model results.
    word_q_t m_words;
    int      m_last;
    bit      m_err;

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic make_stream(input word_q_t w, output byte_q_t s);
        int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
`endif
        s = {};
        n = w.size();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        foreach (w[k]) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] v;
                v = w[k][8*b +: 8];
                s.push_back(v);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x ^= v;
`endif
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
    endtask

    // Parses a byte stream by the format rules: expected words, index of the
    // final byte the loader should consume, and whether the image is malformed.
    task automatic model_image(input byte_q_t s);
        int n;
        m_words = {};
        m_err   = 1'b0;
        n = int'(s[0]) | (int'(s[1]) << 8);
        if (n > (1 << AW)) begin
            m_err  = 1'b1;
            m_last = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            m_words.push_back({s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]});
        end
        m_last = 2 + 4 * n - 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 2; i <= m_last; i++) x ^= s[i];
            m_last++;
            m_err = (s[m_last] != x);
        end
`endif
    endtask

    // mode 0: valid held, 1: valid toggles every cycle, 2: random valid.
    task automatic drive_stream(input byte_q_t s, input int mode);
        int idx  = 0;
        int tail = 0;
        bit v;
        acc_cyc = {};
        st_addr = {};
        st_data = {};
        st_cyc  = {};
        done_cyc  = -1;
        err_cyc   = -1;
        crst_fall = -1;
        for (int n = 0; n < 20000 && tail < 4; n++) begin
            @(negedge clk);
            if (imem_ld) begin
                st_addr.push_back(int'(imem_ld_addr));
                st_data.push_back(imem_ld_data);
                st_cyc.push_back(cyc);
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (err && err_cyc < 0) err_cyc = cyc;
            if (!core_rst && crst_fall < 0) crst_fall = cyc;
            if (idx < s.size()) begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) :
                    ($urandom_range(0, 3) != 0);
                byte_valid = v;
                byte_data  = s[idx];
                if (v && byte_ready) begin
                    acc_cyc.push_back(cyc);
                    idx++;
                end
            end else begin
                byte_valid = 1'b0;
            end
            if (done_cyc >= 0 || err_cyc >= 0 || idx == s.size()) tail++;
        end
        consumed = idx;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h5a;
        repeat (2) @(negedge clk);
        checks++; if (byte_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b expected 1", byte_ready); end
        checks++; if (imem_ld !== 1'b0) begin errors++;
            $display("FAIL reset_ld got %b expected 0", imem_ld); end
        checks++; if (imem_ld_addr !== '0) begin errors++;
            $display("FAIL reset_addr got %0h expected 0", imem_ld_addr); end
        checks++; if (imem_ld_data !== 32'd0) begin errors++;
            $display("FAIL reset_data got %08h expected 0", imem_ld_data); end
        checks++; if (core_rst !== 1'b1) begin errors++;
            $display("FAIL reset_core_rst got %b expected 1", core_rst); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b expected 0", err); end
        rst        = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic test_image_stream(input byte_q_t s, input int mode, input string name);
        int exp_c;
        apply_reset();
        model_image(s);
        drive_stream(s, mode);
        checks++; if (consumed !== m_last + 1) begin errors++;
            $display("FAIL %s consumed got %0d expected %0d", name, consumed, m_last + 1); end
        checks++; if (st_addr.size() !== m_words.size()) begin errors++;
            $display("FAIL %s strobes got %0d expected %0d", name, st_addr.size(), m_words.size());
        end
        foreach (m_words[k]) begin
            if (k < st_addr.size()) begin
                exp_c = (2 + 4 * k + 3 < acc_cyc.size()) ? acc_cyc[2+4*k+3] + 1 : -99;
                checks++; if (st_addr[k] !== k) begin errors++;
                    $display("FAIL %s addr[%0d] got %0d expected %0d", name, k, st_addr[k], k); end
                checks++; if (st_data[k] !== m_words[k]) begin errors++;
                    $display("FAIL %s data[%0d] got %08h expected %08h", name, k, st_data[k],
                             m_words[k]); end
                checks++; if (st_cyc[k] !== exp_c) begin errors++;
                    $display("FAIL %s strobe_cycle[%0d] got %0d expected %0d", name, k,
                             st_cyc[k], exp_c); end
            end
        end
        exp_c = (m_last < acc_cyc.size()) ? acc_cyc[m_last] : -99;
        if (m_err) begin
            checks++; if (err_cyc !== exp_c + 1) begin errors++;
                $display("FAIL %s err_cycle got %0d expected %0d", name, err_cyc, exp_c + 1); end
            checks++; if (done_cyc !== -1) begin errors++;
                $display("FAIL %s done got cycle %0d expected never", name, done_cyc); end
            checks++; if (crst_fall !== -1) begin errors++;
                $display("FAIL %s core_rst fell at %0d expected never", name, crst_fall); end
        end else begin
            checks++; if (done_cyc !== exp_c + 2) begin errors++;
                $display("FAIL %s done_cycle got %0d expected %0d", name, done_cyc, exp_c + 2); end
            checks++; if (crst_fall !== exp_c + 2) begin errors++;
                $display("FAIL %s core_rst_fall got %0d expected %0d", name, crst_fall,
                         exp_c + 2); end
            checks++; if (err_cyc !== -1) begin errors++;
                $display("FAIL %s err got cycle %0d expected never", name, err_cyc); end
        end
        checks++; if (byte_ready !== 1'b0) begin errors++;
            $display("FAIL %s final_ready got %b expected 0", name, byte_ready); end
    endtask

    task automatic test_mid_reset();
        byte_q_t s;
        word_q_t w;
        apply_reset();
        s = {8'h02, 8'h00, 8'h11, 8'h22};
        drive_stream(s, 0);
        // Reset while a byte is also offered: the byte must be dropped.
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        @(negedge clk);
        rst        = 1'b0;
        byte_valid = 1'b0;
        w = {32'hefbeadde};
        make_stream(w, s);
        drive_stream(s, 0);
        checks++; if (st_addr.size() !== 1) begin errors++;
            $display("FAIL mid_reset strobes got %0d expected 1", st_addr.size()); end
        if (st_addr.size() > 0) begin
            checks++; if (st_addr[0] !== 0) begin errors++;
                $display("FAIL mid_reset addr got %0d expected 0", st_addr[0]); end
            checks++; if (st_data[0] !== 32'hefbeadde) begin errors++;
                $display("FAIL mid_reset data got %08h expected efbeadde", st_data[0]); end
        end
        checks++; if (done_cyc < 0) begin errors++;
            $display("FAIL mid_reset done got never expected asserted"); end
    endtask

    initial begin
        byte_q_t s;
        word_q_t w;
        int      n;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        test_reset();

        w = {32'h00000013, 32'h00100073};
        make_stream(w, s);
        test_image_stream(s, 0, "two_words_held");
        test_image_stream(s, 1, "two_words_toggle");

        s = {8'h01, 8'h04, 8'haa, 8'hbb, 8'hcc, 8'hdd};
        test_image_stream(s, 0, "oversize_1025");

        w = {};
        make_stream(w, s);
        s.push_back(8'h99);
        test_image_stream(s, 0, "empty_image");

        for (int r = 0; r < 4; r++) begin
            w = {};
            n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) w.push_back($urandom);
            make_stream(w, s);
            s.push_back(8'(r));
            test_image_stream(s, (r % 2 == 0) ? 2 : 1, "random_image");
        end

        w = {};
        for (int k = 0; k < (1 << AW); k++) w.push_back($urandom);
        make_stream(w, s);
        test_image_stream(s, 0, "full_depth");

        test_mid_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h00};
        test_image_stream(s, 0, "csum_good");
        s = {8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h01};
        test_image_stream(s, 0, "csum_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
